multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM processor. It sits directly upstream of the datapath.
- Consumes the latched instruction fields and ALUFlags from the datapath. Drives every datapath control input plus MemWrite to memory.
- Contains four parts: the main FSM, the ALU decoder, the instruction decoder (RegSrc/ImmSrc), and conditional-execution logic with the NZCV flags register.

Parameters:
- None. Fixed ARM subset: ADD, SUB, AND, ORR (reg/imm), LDR, STR (imm offset), B.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low; low at a rising clk edge resets the block
Cond  input  4  Instr[31:28]
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
ALUFlags  input  4  {N,Z,C,V} from datapath ALU, current cycle
PCWrite  output  1  PC register enable
RegWrite  output  1  register file write enable
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0=PC, 1=ALUOut/result path
RegSrc  output  2  [0]=1 selects R15 for RA1; [1]=1 selects Rd for RA2
ALUSrcA  output  2  00=A register, 01=PC, 10/11 reserved (drive 00)
ALUSrcB  output  2  00=WriteData register, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data register, 10=ALUResult
ImmSrc  output  2  equals Op
ALUControl  output  3  000=ADD, 001=SUB, 010=AND, 011=ORR

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset (reset=0 at an edge):
  - state<=FETCH, Flags<=4'b0000, CondExR<=0.
  - While reset=0, PCWrite, RegWrite, MemWrite and IRWrite are forced to 0. Select outputs show FETCH values.
  - A reset in any state abandons the instruction; no partial write occurs.
- Decoder: RegSrc[0]=(Op==10); RegSrc[1]=(Op==01); ImmSrc=Op. All combinational and independent of state.
- FSM states and controls (unlisted enables=0, unlisted selects=00):
  - FETCH: AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExR.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExR.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl=ALU decoder output.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUControl=ALU decoder output.
  - ALUWB: ResultSrc=00, RegWrite=CondExR.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondExR.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER, Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH (undefined instruction, no effect).
  - MEMADR: Funct[0]=1->MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
  - Cycle counts: data-processing 4, LDR 5, STR 4, B 3.
- ALU decoder:
  - cmd 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR; any other cmd->ADD with flags not written.
  - FlagW: S=1 with ADD/SUB=2'b11; S=1 with AND/ORR=2'b10; otherwise 2'b00.
- Conditional logic:
  - CondEx is evaluated combinationally from Cond and the Flags register:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
    - AL 1; 1111 treated as 1
  - CondExR<=CondEx at the end of the DECODE cycle only; it holds until the next DECODE.
- Flags register update:
  - Updates only at the end of EXECUTER/EXECUTEI, and only if CondExR=1.
  - FlagW[1] loads Flags[3:2]<=ALUFlags[3:2] (N,Z); FlagW[0] loads Flags[1:0]<=ALUFlags[1:0] (C,V).
- Rd=R15 writes from data-processing or LDR are unsupported; the block treats them as ordinary register writes.

Test Plan:
- Reset held low 3 cycles, then released -> first edge after release in FETCH with IRWrite=1, PCWrite=1; during reset all four write enables=0 and Flags=0000.
- ADD R1,R2,#5 (Cond=E, Op=00, Funct=101000) -> states FETCH, DECODE, EXECUTEI, ALUWB; ALUSrcB=01, ALUControl=000; RegWrite=1 only in ALUWB; Flags unchanged.
- LDR R3,[R0,#8] (Op=01, Funct=011001) -> 5-cycle sequence ending MEMWB with ResultSrc=01, RegWrite=1; STR (Funct=011000) -> MEMWR with MemWrite=1, AdrSrc=1; RegSrc=10 on both.
- SUBS R4,R4,#1 (Funct=100101) with ALUFlags=0110 in EXECUTEI -> Flags=0110; then BEQ (Cond=0, Op=10) -> BRANCH with PCWrite=1, RegSrc=01; repeated with Flags Z=0 -> PCWrite=0 in BRANCH.
- ADDEQ-S with Z=0 (Cond=0, Funct=101001), ALUFlags=1000 -> RegWrite=0 in ALUWB, Flags unchanged.
- Reset asserted during MEMWR of STR -> MemWrite=0 that cycle; next state FETCH; CondExR=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM subset.
// Contains the main FSM, the ALU decoder, the RegSrc/ImmSrc decoder, and conditional execution with the NZCV register.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    state_t     state, state_next;
    logic [3:0] flags;
    logic       cond_ex_r;
    logic       cond_ex;
    logic [2:0] alu_dec;
    logic [1:0] flag_w;

    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign ImmSrc = Op;

    // State, condition latch and NZCV flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            flags     <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) cond_ex_r <= cond_ex;
            if ((state == EXECUTER || state == EXECUTEI) && cond_ex_r) begin
                if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // ALU decoder: unknown commands add without touching flags
    always_comb begin
        alu_dec = ALU_ADD;
        flag_w  = 2'b00;
        unique case (Funct[4:1])
            4'b0100: begin alu_dec = ALU_ADD; flag_w = Funct[0] ? 2'b11 : 2'b00; end
            4'b0010: begin alu_dec = ALU_SUB; flag_w = Funct[0] ? 2'b11 : 2'b00; end
            4'b0000: begin alu_dec = ALU_AND; flag_w = Funct[0] ? 2'b10 : 2'b00; end
            4'b1100: begin alu_dec = ALU_ORR; flag_w = Funct[0] ? 2'b10 : 2'b00; end
            default: begin alu_dec = ALU_ADD; flag_w = 2'b00; end
        endcase
    end

    // Condition check against the stored flags {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b1;
        unique case (Cond)
            4'h0: cond_ex = flags[2];
            4'h1: cond_ex = !flags[2];
            4'h2: cond_ex = flags[1];
            4'h3: cond_ex = !flags[1];
            4'h4: cond_ex = flags[3];
            4'h5: cond_ex = !flags[3];
            4'h6: cond_ex = flags[0];
            4'h7: cond_ex = !flags[0];
            4'h8: cond_ex = flags[1] && !flags[2];
            4'h9: cond_ex = !flags[1] || flags[2];
            4'hA: cond_ex = flags[3] == flags[0];
            4'hB: cond_ex = flags[3] != flags[0];
            4'hC: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_ex = flags[2] || (flags[3] != flags[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // Next state and per-state controls; reset shows FETCH selects with writes blocked
    always_comb begin
        state_next = FETCH;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        unique case (state)
            FETCH: begin
                state_next = DECODE;
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (Op)
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                state_next = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB    = 2'b01;
            end
            MEMRD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex_r;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_r;
            end
            EXECUTER: begin
                state_next = ALUWB;
                ALUControl = alu_dec;
            end
            EXECUTEI: begin
                state_next = ALUWB;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            ALUWB: begin
                RegWrite = cond_ex_r;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_r;
            end
            default: state_next = FETCH;
        endcase
        if (!reset) begin
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model queues the expected control word for every cycle.
// A negedge monitor compares those words against the DUT outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;
    logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    typedef struct packed {
        logic       pcw, rw, mw, irw, adr;
        logic [1:0] regsrc, asa, asb, rs, imms;
        logic [2:0] alu;
        logic [3:0] flags;
        logic       cx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic [3:0] m_flags;
    logic       m_cx;
    logic       aborted;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    // Monitor: one expected word per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pcw = PCWrite; a.rw = RegWrite; a.mw = MemWrite; a.irw = IRWrite; a.adr = AdrSrc;
            a.regsrc = RegSrc; a.asa = ALUSrcA; a.asb = ALUSrcB; a.rs = ResultSrc;
            a.imms = ImmSrc; a.alu = ALUControl; a.flags = dut.flags; a.cx = dut.cond_ex_r;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL ctl t=%0t got=%h want=%h (pcw rw mw irw adr regsrc asa asb rs imm alu flags cx)",
                         $time, a, e);
            end
        end
    end

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] alu_model(input logic [3:0] cmd, input logic s);
        case (cmd)
            4'b0100: return {3'b000, s ? 2'b11 : 2'b00};
            4'b0010: return {3'b001, s ? 2'b11 : 2'b00};
            4'b0000: return {3'b010, s ? 2'b10 : 2'b00};
            4'b1100: return {3'b011, s ? 2'b10 : 2'b00};
            default: return 5'b000_00;
        endcase
    endfunction

    function automatic exp_t mk(input logic pcw, rw, mw, irw, adr,
                                input logic [1:0] asa, asb, rs, input logic [2:0] alu);
        exp_t e;
        e.pcw = pcw; e.rw = rw; e.mw = mw; e.irw = irw; e.adr = adr;
        e.regsrc = {Op == 2'b01, Op == 2'b10};
        e.asa = asa; e.asb = asb; e.rs = rs; e.imms = Op; e.alu = alu;
        e.flags = m_flags; e.cx = m_cx;
        return e;
    endfunction

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Emit one cycle, or a reset cycle in its place when this is the abort point
    task automatic emit(input exp_t w, input int k, input int abort);
        if (!aborted) begin
            if (k == abort) begin
                reset = 1'b0;
                step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000));
                reset = 1'b1;
                m_flags = 4'b0000;
                m_cx = 1'b0;
                aborted = 1'b1;
            end else begin
                step(w);
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] xflags, input int abort);
        logic [4:0] ad;
        aborted = 1'b0;
        Cond = c; Op = op; Funct = f; ALUFlags = 4'($urandom);
        emit(mk(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'b000), 0, abort);
        emit(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000), 1, abort);
        if (!aborted) m_cx = cond_ok(c, m_flags);
        case (op)
            2'b00: begin
                ad = alu_model(f[4:1], f[0]);
                ALUFlags = xflags;
                emit(mk(0, 0, 0, 0, 0, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00, ad[4:2]), 2, abort);
                if (!aborted && m_cx) begin
                    if (ad[1]) m_flags[3:2] = xflags[3:2];
                    if (ad[0]) m_flags[1:0] = xflags[1:0];
                end
                ALUFlags = 4'($urandom);
                emit(mk(0, m_cx, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000), 3, abort);
            end
            2'b01: begin
                emit(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000), 2, abort);
                if (f[0]) begin
                    emit(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000), 3, abort);
                    emit(mk(0, m_cx, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000), 4, abort);
                end else begin
                    emit(mk(0, 0, m_cx, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000), 3, abort);
                end
            end
            2'b10: emit(mk(m_cx, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000), 2, abort);
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] rc;
        logic [1:0] rop;
        logic [5:0] rf;
        int         rab;
        reset = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'd0; ALUFlags = 4'd0;
        m_flags = 4'b0000; m_cx = 1'b0; aborted = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000));
        reset = 1'b1;

        run_instr(4'hE, 2'b00, 6'b101000, 4'b1111, -1);   // ADD R1,R2,#5
        run_instr(4'hE, 2'b01, 6'b011001, 4'b0000, -1);   // LDR
        run_instr(4'hE, 2'b01, 6'b011000, 4'b0000, -1);   // STR
        run_instr(4'hE, 2'b00, 6'b100101, 4'b0110, -1);   // SUBS -> Z=1
        run_instr(4'h0, 2'b10, 6'b000000, 4'b0000, -1);   // BEQ taken
        run_instr(4'hE, 2'b00, 6'b100101, 4'b0000, -1);   // SUBS -> Z=0
        run_instr(4'h0, 2'b10, 6'b000000, 4'b0000, -1);   // BEQ not taken
        run_instr(4'h0, 2'b00, 6'b101001, 4'b1000, -1);   // ADDEQS skipped

        for (int i = 0; i < 400; i++) begin
            rop = 2'($urandom_range(0, 3));
            rc  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
            rf  = 6'($urandom);
            if (rop == 2'b00 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: rf[4:1] = 4'b0100;
                    1: rf[4:1] = 4'b0010;
                    2: rf[4:1] = 4'b0000;
                    default: rf[4:1] = 4'b1100;
                endcase
            end
            rab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(rc, rop, rf, 4'($urandom), rab);
        end

        run_instr(4'hE, 2'b01, 6'b011000, 4'b0000, 3);    // reset during MEMWR
        run_instr(4'hE, 2'b00, 6'b000000, 4'b0000, -1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
